// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative HI/LO multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    localparam int          MD_ITER = 32;
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    // Magnitude of a two's-complement word when en is set, pass-through otherwise.
    function automatic logic [31:0] md_abs(input logic signed [31:0] v, input logic en);
        logic signed [31:0] neg;
        neg = -v;
        return (en && v[31]) ? neg : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the 64-bit accumulator: shift-add multiply or restoring subtract-shift divide.
module muldiv_step #(
    parameter int DATA_W = 32
) (
    input  logic                  is_div,
    input  logic [2*DATA_W-1:0]   acc,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   acc_next
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] rem;
    logic [DATA_W:0] diff;

    always_comb begin
        sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, b} : {(DATA_W+1){1'b0}});
        rem  = acc[2*DATA_W-1:DATA_W-1];
        diff = rem - {1'b0, b};
        acc_next = {sum, acc[DATA_W-1:1]};
        // Top bit of diff is the borrow: restore (keep rem) when the divisor did not fit.
        if (is_div) begin
            if (!diff[DATA_W])
                acc_next = {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
            else
                acc_next = {rem[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with MTHI/MTLO and MFHI/MFLO stall.
// Optional MULDIV_FAST_MULT_EN: multiplies complete in one registered cycle.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic              flush,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_req,
    output logic              busy,
    output logic              done,
    output logic              stall,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    md_state_e           state;
    md_op_e              op_q;
    logic [4:0]          cnt;
    logic                neg_res;
    logic                neg_rem;
    logic                div0;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] acc_next;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   op1_raw;

    logic              sgn_op;
    logic              s1;
    logic              s2;
    logic [DATA_W-1:0] abs1;
    logic [DATA_W-1:0] abs2;
    logic              accept;
    logic              wr_ok;

    assign sgn_op = ~op[0];
    assign s1     = sgn_op & op1[DATA_W-1];
    assign s2     = sgn_op & op2[DATA_W-1];
    assign abs1   = md_abs(op1, sgn_op);
    assign abs2   = md_abs(op2, sgn_op);
    assign accept = (state == MD_IDLE) && start && !flush;
    assign wr_ok  = (state == MD_IDLE) && !accept;
    assign stall  = rd_req & busy;

`ifdef MULDIV_FAST_MULT_EN
    logic signed [2*DATA_W-1:0] sx1;
    logic signed [2*DATA_W-1:0] sx2;
    logic        [2*DATA_W-1:0] prod_fast;

    always_comb begin
        sx1 = op[0] ? {{DATA_W{1'b0}}, op1} : {{DATA_W{op1[DATA_W-1]}}, op1};
        sx2 = op[0] ? {{DATA_W{1'b0}}, op2} : {{DATA_W{op2[DATA_W-1]}}, op2};
        prod_fast = sx1 * sx2;
    end
`endif

    muldiv_step #(.DATA_W(DATA_W)) u_step (
        .is_div   (op_q[1]),
        .acc      (acc),
        .b        (b_q),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= MD_IDLE;
            op_q    <= MD_MULT;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= MD_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    MD_IDLE: if (start) begin
                        op_q    <= md_op_e'(op);
                        busy    <= 1'b1;
                        cnt     <= 5'(MD_ITER - 1);
                        state   <= MD_CALC;
                        neg_res <= s1 ^ s2;
                        neg_rem <= s1;
                        div0    <= op[1] && (op2 == '0);
`ifdef MULDIV_FAST_MULT_EN
                        if (!op[1]) begin
                            state   <= MD_FIX;
                            neg_res <= 1'b0;
                        end
`endif
                    end
                    MD_CALC: begin
                        cnt <= cnt - 5'd1;
                        if (cnt == '0)
                            state <= MD_FIX;
                    end
                    MD_FIX: begin
                        if (!op_q[1]) begin
                            {hi, lo} <= neg_res ? -acc : acc;
                        end else if (div0) begin
                            lo <= DIV0_LO;
                            hi <= op1_raw;
                        end else begin
                            lo <= neg_res ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
                            hi <= neg_rem ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
                        end
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= MD_IDLE;
                    end
                    default: state <= MD_IDLE;
                endcase
            end
            if (wr_ok) begin
                if (mthi) hi <= wdata;
                if (mtlo) lo <= wdata;
            end
        end
    end

    // Datapath registers carry no reset; they are always loaded on an accepted start.
    always_ff @(posedge clk) begin
        if (accept) begin
            op1_raw <= op1;
            if (op[1]) begin
                acc <= {{DATA_W{1'b0}}, abs1};
                b_q <= abs2;
            end else begin
                acc <= {{DATA_W{1'b0}}, abs2};
                b_q <= abs1;
            end
`ifdef MULDIV_FAST_MULT_EN
            if (!op[1])
                acc <= prod_fast;
`endif
        end else if (state == MD_CALC) begin
            acc <= acc_next;
        end
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle multiply/divide sequencer owning the architectural HI/LO registers of the MIPS CPU. It accepts MULT/MULTU/DIV/DIVU from the execute stage and runs an iterative 32-step shift-add or restoring-divide loop. It services MTHI/MTLO writes and raises a stall when MFHI/MFLO reads HI/LO while an operation is in flight. It replaces the single-cycle combinational mul/div path, so the execute-stage ALU keeps only its single-cycle functions.

## Interface
- `DATA_W`, 32: operand/HI/LO width; only 32 is supported.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: launch operation (sampled when idle).
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `op1` in 32: multiplicand / dividend (rs).
- `op2` in 32: multiplier / divisor (rt).
- `flush` in 1: abort in-flight operation.
- `mthi`, `mtlo` in 1: write `wdata` to HI/LO.
- `wdata` in 32: MTHI/MTLO data.
- `rd_req` in 1: MFHI/MFLO in execute this cycle.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse when HI/LO takes a new result.
- `stall` out 1: `rd_req & busy`.
- `hi`, `lo` out 32: registered HI/LO.

## Operation
- FSM states: IDLE, CALC, FIX.
  - IDLE→CALC when `start` is high and `flush` is low. The block latches operands: absolute values for signed ops, the sign flags, and the op. It loads the iteration counter to 31.
  - CALC: one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle. The counter decrements each cycle. At counter 0 the FSM goes to FIX.
  - FIX: applies sign correction, writes HI/LO, pulses `done`, and goes to IDLE.
- Multiply: {HI,LO} is the 64-bit product. Signed ops negate the product when the operand signs differ.
- Divide: LO is the quotient and HI is the remainder. Signed ops truncate toward zero and the remainder takes the dividend's sign.
  - −2^31 / −1 gives LO=0x80000000, HI=0.
- Divide by zero, both DIV and DIVU: LO=0xFFFFFFFF, HI=op1 unmodified, with no sign fixup. Cycle count is the same as a normal divide.
- `start` while busy is ignored; the issuing stage must not issue it.
- `mthi`/`mtlo` while idle write at the next edge.
  - While busy they are ignored.
  - In the same cycle as an accepted `start`, `start` wins and the writes are dropped.
  - `mthi` and `mtlo` together write both registers.
- `flush` in any state returns the FSM to IDLE at the next edge. HI/LO keep their values and no `done` pulse is produced. A `start` in the same cycle as `flush` is dropped.
- `busy` is high whenever the state is not IDLE.

## Timing
- Reset values: state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, `stall`=0, counter 0.
- `start` is accepted at edge E0. `busy` goes high after E0. The FSM is in CALC for 32 cycles and in FIX after E32. HI/LO update and `done`=1 after E33, and `busy` drops at the same time.
- Start-to-result latency is 33 cycles. Back-to-back issue is possible: a new `start` may be accepted in the cycle `done` is high.
- `stall` is combinational from `rd_req` and the registered `busy`. It is low in the `done` cycle, so MFHI/MFLO in that cycle reads the new values.
- Asserting `reset` mid-operation immediately forces all reset values.

## Configuration
- `MULDIV_FAST_MULT_EN`
  - Defined: MULT/MULTU compute with a single registered `*` (signed/unsigned). The FSM goes IDLE→FIX directly, so `done` and the result arrive after E1. Divide is unchanged at 33 cycles.
  - Undefined: the iterative 32-step multiply is used and the `*` operator does not appear in the RTL.

## Structure
- `muldiv_pkg`:
  - op enum: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - state enum: MD_IDLE, MD_CALC, MD_FIX.
  - constant MD_ITER=32.
  - DIV0_LO=32'hFFFFFFFF.
- One sub-module, `muldiv_step`: combinational single-iteration datapath (add-shift or subtract-shift on the 64-bit accumulator), selected by op class.
- The FSM, counter, sign fixup and HI/LO registers live in `muldiv_seq`.

## Test plan
- MULT op1=0xFFFFFFFF, op2=2 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU with the same operands → hi=1, lo=0xFFFFFFFE.
- DIV op1=−7 (0xFFFFFFF9), op2=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 → lo=14, hi=2.
- DIVU op1=0x1234, op2=0 → lo=0xFFFFFFFF, hi=0x1234; DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Start MULTU 3×5, assert `rd_req` at cycles 1..33 → `stall` is high through cycle 32 and low in the `done` cycle. `mtlo` with wdata=9 while busy is ignored, giving lo=15.
- Idle `mthi`=0xAAAA → hi=0xAAAA. Start DIVU then `flush` at cycle 10 → busy drops next cycle, no `done` pulse, hi=0xAAAA. Assert `reset` mid-op → hi=lo=0, busy=0.
- With `MULDIV_FAST_MULT_EN`: MULT 6×−3 → `done` one cycle after start, hi=0xFFFFFFFF, lo=0xFFFFFFEE.
